rtc_read_sequencer: RTL and testbench

Parametrised read sequencer for the multiplexed address/data RTC bus.
- On `start`, issues the clock- or timer-transfer command, then walks a programmable list of register addresses and captures each returned byte into an output bank.
- Sits between the main control FSM and the bus-timing generator, which supplies the `dir_phase`, `dat_phase` and `step` strobes.
- Generalises the fixed 7-step clock/timer read: per-mode register count, address table, abort input and step timeout.

---
 rtl/rtc_read_sequencer_if.sv | 46 ++++
 rtl/rtc_read_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_read_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_read_sequencer_if
//  Brief    : Control/bus bundle between the RTC read sequencer, its
//             controlling FSM and the bus-timing generator.
//  Revision : 1.0 - initial release
// ============================================================================
interface rtc_read_sequencer_if #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int CW   = 4
);
  logic                 start;
  logic                 abort;
  logic                 mode;
  logic [CW-1:0]        n_clk;
  logic [CW-1:0]        n_tmr;
  logic [NREG*DW-1:0]   addr_list;
  logic                 dir_phase;
  logic                 dat_phase;
  logic                 step;
  logic [DW-1:0]        rd_data;
  logic                 busy;
  logic                 xfer;
  logic [DW-1:0]        cmd_data;
  logic [DW-1:0]        addr_out;
  logic [NREG*DW-1:0]   regs_out;
  logic [NREG-1:0]      valid;
  logic                 done;
  logic                 err;

  // Controller / bus-timing side
  modport master (
    output start, abort, mode, n_clk, n_tmr, addr_list,
           dir_phase, dat_phase, step, rd_data,
    input  busy, xfer, cmd_data, addr_out, regs_out, valid, done, err
  );

  // Sequencer side
  modport slave (
    input  start, abort, mode, n_clk, n_tmr, addr_list,
           dir_phase, dat_phase, step, rd_data,
    output busy, xfer, cmd_data, addr_out, regs_out, valid, done, err
  );
endinterface
`default_nettype wire

// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_read_sequencer
//  Brief    : Issues the clock/timer transfer command on the multiplexed
//             RTC bus, then reads a programmable list of registers into an
//             output bank. Supports abort and a no-step timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_read_sequencer #(
  parameter int            DW      = 8,
  parameter int            NREG    = 8,
  parameter int            CW      = 4,
  parameter int            TMO     = 1024,
  parameter logic [DW-1:0] CMD_CLK = 8'hF1,
  parameter logic [DW-1:0] CMD_TMR = 8'hF2,
  parameter logic [DW-1:0] CMD_DAT = 8'h01
) (
  input  logic                 clk,
  input  logic                 reset,
  rtc_read_sequencer_if.slave  bus
);

  localparam int            TW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [CW-1:0] NREG_C   = CW'(NREG);
  localparam logic [DW-1:0] ADDR_IDLE = {DW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               busy_q, busy_d;
  logic               xfer_q, xfer_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DW-1:0]      addr_q, addr_d;
  logic [NREG*DW-1:0] regs_q, regs_d;
  logic [NREG-1:0]    valid_q, valid_d;

  logic [CW-1:0]      w_n_req;
  logic [CW-1:0]      w_cnt;
  logic [DW-1:0]      w_slot_addr;

  // Requested count for the selected mode, saturated at the bank size
  always_comb begin
    w_n_req = bus.mode ? bus.n_tmr : bus.n_clk;
    w_cnt   = (w_n_req > NREG_C) ? NREG_C : w_n_req;
  end

  // Address table entry for the slot currently being read
  always_comb begin
    w_slot_addr = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_q == CW'(i)) w_slot_addr = bus.addr_list[i*DW +: DW];
    end
  end

  // Next-state and output logic; abort beats timeout beats the strobes
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    xfer_d  = xfer_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    regs_d  = regs_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        addr_d = ADDR_IDLE;
        busy_d = 1'b0;
        xfer_d = 1'b0;
        tmo_d  = '0;
        if (bus.start) begin
          mode_d  = bus.mode;
          cnt_d   = w_cnt;
          valid_d = '0;
          busy_d  = 1'b1;
          state_d = S_CMD;
        end
      end

      S_CMD, S_READ: begin
        if (bus.abort || (!bus.step && tmo_q == TMO_LAST)) begin
          // Both exits drop the bus request; only the timeout reports err
          err_d   = ~bus.abort;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          xfer_d  = 1'b0;
          addr_d  = ADDR_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = bus.step ? '0 : tmo_q + TW'(1);
          if (bus.dir_phase) begin
            if (state_q == S_CMD) addr_d = mode_q ? CMD_TMR : CMD_CLK;
            else                  addr_d = w_slot_addr;
          end else if (bus.dat_phase) begin
            if (state_q == S_CMD) begin
              xfer_d = 1'b1;
            end else begin
              for (int i = 0; i < NREG; i++) begin
                if (idx_q == CW'(i)) begin
                  regs_d[i*DW +: DW] = bus.rd_data;
                  valid_d[i]         = 1'b1;
                end
              end
            end
          end else if (bus.step) begin
            xfer_d = 1'b0;
            if ((state_q == S_CMD && cnt_q == '0) ||
                (state_q == S_READ && idx_q == cnt_q - CW'(1))) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (state_q == S_CMD) begin
              idx_d   = '0;
              state_d = S_READ;
            end else begin
              idx_d = idx_q + CW'(1);
            end
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        addr_d  = ADDR_IDLE;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      xfer_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= ADDR_IDLE;
      regs_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      xfer_q  <= xfer_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      regs_q  <= regs_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.xfer     = xfer_q;
  assign bus.cmd_data = CMD_DAT;
  assign bus.addr_out = addr_q;
  assign bus.regs_out = regs_q;
  assign bus.valid    = valid_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_read_sequencer
//  Brief    : Randomised bench for rtc_read_sequencer with a slot-level
//             reference model of the register bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_read_sequencer;
  localparam int DW = 8, NREG = 8, CW = 4, TMO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_read_sequencer_if #(.DW(DW), .NREG(NREG), .CW(CW)) bus ();

  rtc_read_sequencer #(
    .DW(DW), .NREG(NREG), .CW(CW), .TMO(TMO),
    .CMD_CLK(8'hF1), .CMD_TMR(8'hF2), .CMD_DAT(8'h01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: what each bank slot should hold and which are fresh
  logic [7:0]      m_regs [NREG];
  logic [NREG-1:0] m_valid;
  logic [7:0]      m_addr [NREG];

  task automatic load_addrs(input bit fixed);
    for (int i = 0; i < NREG; i++) begin
      m_addr[i] = fixed ? 8'(8'h21 + i) : 8'($urandom);
      bus.addr_list[i*DW +: DW] = m_addr[i];
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic pulse_dir();
    gap(); bus.dir_phase = 1'b1; @(negedge clk); bus.dir_phase = 1'b0;
  endtask

  task automatic pulse_dat(input logic [7:0] d);
    gap(); bus.dat_phase = 1'b1; bus.rd_data = d;
    @(negedge clk); bus.dat_phase = 1'b0; bus.rd_data = 8'($urandom);
  endtask

  task automatic pulse_step();
    gap(); bus.step = 1'b1; @(negedge clk); bus.step = 1'b0;
  endtask

  task automatic start_seq(input bit m, input logic [3:0] nc, input logic [3:0] nt);
    @(negedge clk);
    bus.mode = m; bus.n_clk = nc; bus.n_tmr = nt; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 1'($urandom);
    bus.n_clk = 4'($urandom);
    bus.n_tmr = 4'($urandom);
  endtask

  // Full successful sequence, checked slot by slot against the model
  task automatic run_full(input bit m, input logic [3:0] nc, input logic [3:0] nt,
                          input bit fixed, input string tag);
    int cnt;
    logic [7:0] d [NREG];
    logic [7:0] cmd;
    cnt = m ? int'(nt) : int'(nc);
    if (cnt > NREG) cnt = NREG;
    cmd = m ? 8'hF2 : 8'hF1;
    for (int i = 0; i < NREG; i++) d[i] = fixed ? 8'(8'h10 + i) : 8'($urandom);

    start_seq(m, nc, nt);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b want 1", tag, bus.busy); end
    pulse_dir();
    checks++; if (bus.addr_out !== cmd) begin errors++; $display("FAIL %s cmd_addr: got %h want %h", tag, bus.addr_out, cmd); end
    pulse_dat(8'($urandom));
    checks++; if (bus.xfer !== 1'b1) begin errors++; $display("FAIL %s xfer_data_phase: got %b want 1", tag, bus.xfer); end
    checks++; if (bus.cmd_data !== 8'h01) begin errors++; $display("FAIL %s cmd_data: got %h want 01", tag, bus.cmd_data); end
    pulse_step();
    checks++; if (bus.xfer !== 1'b0) begin errors++; $display("FAIL %s xfer_after_step: got %b want 0", tag, bus.xfer); end

    m_valid = '0;
    for (int i = 0; i < cnt; i++) begin
      pulse_dir();
      checks++; if (bus.addr_out !== m_addr[i]) begin errors++; $display("FAIL %s slot%0d_addr: got %h want %h", tag, i, bus.addr_out, m_addr[i]); end
      pulse_dat(d[i]);
      m_regs[i]  = d[i];
      m_valid[i] = 1'b1;
      pulse_step();
    end

    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL %s done_pulse: got %b want 1", tag, bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done: got %b want 0", tag, bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL %s err_in_done: got %b want 0", tag, bus.err); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b want 0", tag, bus.done); end
    checks++; if (bus.addr_out !== 8'hFF) begin errors++; $display("FAIL %s addr_idle: got %h want ff", tag, bus.addr_out); end
    for (int i = 0; i < NREG; i++) begin
      checks++; if (bus.regs_out[i*DW +: DW] !== m_regs[i]) begin errors++; $display("FAIL %s regs[%0d]: got %h want %h", tag, i, bus.regs_out[i*DW +: DW], m_regs[i]); end
    end
    checks++; if (bus.valid !== m_valid) begin errors++; $display("FAIL %s valid: got %h want %h", tag, bus.valid, m_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_valid = '0;
    checks++; if ({bus.busy, bus.xfer, bus.done, bus.err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.xfer, bus.done, bus.err}); end
    checks++; if (bus.addr_out !== 8'hFF) begin errors++; $display("FAIL reset_addr: got %h want ff", bus.addr_out); end
    checks++; if (bus.regs_out !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", bus.regs_out); end
    checks++; if (bus.valid !== '0) begin errors++; $display("FAIL reset_valid: got %h want 0", bus.valid); end
  endtask

  task automatic test_clock_read();
    load_addrs(1'b1);
    run_full(1'b0, 4'd6, 4'($urandom), 1'b1, "clock_read");
  endtask

  task automatic test_timer_mode();
    load_addrs(1'b0);
    run_full(1'b1, 4'($urandom), 4'd3, 1'b0, "timer_mode");
  endtask

  task automatic test_zero_count();
    load_addrs(1'b0);
    run_full(1'b0, 4'd0, 4'($urandom), 1'b0, "zero_count");
  endtask

  task automatic test_saturate();
    load_addrs(1'b0);
    run_full(1'b0, 4'd12, 4'($urandom), 1'b0, "saturate");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      load_addrs(1'b0);
      run_full(1'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, "random");
    end
  endtask

  task automatic test_timeout();
    int waited;
    bit seen_done;
    logic [7:0] d;
    waited = 0; seen_done = 1'b0;
    load_addrs(1'b0);
    start_seq(1'b0, 4'd5, 4'd0);
    pulse_dir(); pulse_dat(8'($urandom)); pulse_step();
    m_valid = '0;
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      pulse_dir(); pulse_dat(d); pulse_step();
      m_regs[i] = d; m_valid[i] = 1'b1;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
      if (bus.err === 1'b1) begin waited = k; break; end
    end
    checks++; if (waited !== 16) begin errors++; $display("FAIL timeout_latency: got %0d want 16", waited); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", bus.busy); end
    checks++; if (bus.addr_out !== 8'hFF) begin errors++; $display("FAIL timeout_addr: got %h want ff", bus.addr_out); end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL timeout_no_done: got %b want 0", seen_done); end
    checks++; if (bus.valid !== m_valid) begin errors++; $display("FAIL timeout_valid: got %h want %h", bus.valid, m_valid); end
    for (int i = 0; i < NREG; i++) begin
      checks++; if (bus.regs_out[i*DW +: DW] !== m_regs[i]) begin errors++; $display("FAIL timeout_regs[%0d]: got %h want %h", i, bus.regs_out[i*DW +: DW], m_regs[i]); end
    end
    @(negedge clk);
    checks++; if ({bus.err, bus.done} !== 2'b00) begin errors++; $display("FAIL timeout_err_width: got %b want 00", {bus.err, bus.done}); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    load_addrs(1'b0);
    start_seq(1'b0, 4'd3, 4'd0);
    pulse_dir(); pulse_dat(8'($urandom)); pulse_step();
    m_valid = '0;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      pulse_dir(); pulse_dat(d);
      m_regs[i] = d; m_valid[i] = 1'b1;
      if (i < 2) pulse_step();
    end
    gap();
    bus.step = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.step = 1'b0; bus.abort = 1'b0;
    checks++; if ({bus.done, bus.err, bus.busy, bus.xfer} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b want 0000", {bus.done, bus.err, bus.busy, bus.xfer}); end
    checks++; if (bus.addr_out !== 8'hFF) begin errors++; $display("FAIL abort_addr: got %h want ff", bus.addr_out); end
    checks++; if (bus.valid !== m_valid) begin errors++; $display("FAIL abort_valid: got %h want %h", bus.valid, m_valid); end
    @(negedge clk);
    checks++; if ({bus.done, bus.err, bus.busy} !== 3'b000) begin errors++; $display("FAIL abort_after: got %b want 000", {bus.done, bus.err, bus.busy}); end
    for (int i = 0; i < NREG; i++) begin
      checks++; if (bus.regs_out[i*DW +: DW] !== m_regs[i]) begin errors++; $display("FAIL abort_regs[%0d]: got %h want %h", i, bus.regs_out[i*DW +: DW], m_regs[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    load_addrs(1'b0);
    start_seq(1'b1, 4'd2, 4'd5);
    pulse_dir(); pulse_dat(8'($urandom)); pulse_step();
    pulse_dir(); pulse_dat(8'($urandom));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_valid = '0;
    checks++; if ({bus.busy, bus.xfer, bus.done, bus.err} !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got %b want 0000", {bus.busy, bus.xfer, bus.done, bus.err}); end
    checks++; if (bus.addr_out !== 8'hFF) begin errors++; $display("FAIL midreset_addr: got %h want ff", bus.addr_out); end
    checks++; if (bus.regs_out !== '0) begin errors++; $display("FAIL midreset_regs: got %h want 0", bus.regs_out); end
    checks++; if (bus.valid !== '0) begin errors++; $display("FAIL midreset_valid: got %h want 0", bus.valid); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.n_clk = '0; bus.n_tmr = '0; bus.addr_list = '0;
    bus.dir_phase = 1'b0; bus.dat_phase = 1'b0; bus.step = 1'b0; bus.rd_data = '0;
    test_reset();
    test_clock_read();
    test_timer_mode();
    test_zero_count();
    test_saturate();
    test_random();
    test_timeout();
    test_abort();
    test_random();
    test_reset_mid_read();
    test_clock_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
